// File: rtl/wave_gen_if.sv
// Control and sample bus of the multi-mode waveform source.
// The controller drives the master side; wave_gen sits on the slave side.
interface wave_gen_if #(
    parameter int WIDTH = 16
) ();
    // Handshake: en is a per-cycle valid qualifier with no ready or backpressure.
    // load overrides en. out/wrap are registered and describe the state that the
    // most recent edge produced.
    logic             en;
    logic             load;
    logic [1:0]       mode;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             dbg_dir;

    modport master (
        output en, load, mode, step, seed,
        input  out, wrap, dbg_dir
    );

    modport slave (
        input  en, load, mode, step, seed,
        output out, wrap, dbg_dir
    );
endinterface

// File: rtl/wave_gen.sv
// Multi-mode waveform source: triangle, sawtooth, square and Galois LFSR noise,
// advancing one sample per enabled clock, with seed load and a period-end pulse.
module wave_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input logic        clk,
    input logic        rst,
    wave_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_TRI   = 2'd0,
        MODE_SAW   = 2'd1,
        MODE_SQR   = 2'd2,
        MODE_NOISE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] acc_q, acc_d;
    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    mode_t            mode;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] headroom;
    logic [WIDTH-1:0] tri_acc;
    dir_t             tri_dir;
    logic             tri_wrap;
    logic [WIDTH-1:0] noise_acc;
    logic             noise_wrap;

    assign mode = mode_t'(bus.mode);

    // Headroom is computed as MAX-acc so the up-clamp test never overflows.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, bus.step};
        headroom = MAX - acc_q;
    end

    always_comb begin
        tri_acc  = acc_q;
        tri_dir  = dir_q;
        tri_wrap = 1'b0;
        if (bus.step != '0) begin
            if (dir_q == DIR_UP) begin
                if (headroom <= bus.step) begin
                    tri_acc = MAX;
                    tri_dir = DIR_DOWN;
                end else begin
                    tri_acc = acc_q + bus.step;
                end
            end else begin
                if (acc_q <= bus.step) begin
                    tri_acc  = '0;
                    tri_dir  = DIR_UP;
                    tri_wrap = 1'b1;
                end else begin
                    tri_acc = acc_q - bus.step;
                end
            end
        end
    end

    // An all-zero register would lock the LFSR, so it is kicked to 1.
    always_comb begin
        noise_acc = '0;
        if (acc_q == '0) begin
            noise_acc = ONE;
        end else begin
            noise_acc = (acc_q >> 1) ^ (acc_q[0] ? TAPS : '0);
        end
        noise_wrap = (noise_acc == RESET_VAL);
    end

    always_comb begin
        acc_d  = acc_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            acc_d = bus.seed;
            dir_d = DIR_UP;
        end else if (bus.en) begin
            case (mode)
                MODE_TRI: begin
                    acc_d  = tri_acc;
                    dir_d  = tri_dir;
                    wrap_d = tri_wrap;
                end
                MODE_SAW, MODE_SQR: begin
                    acc_d  = sum[WIDTH-1:0];
                    wrap_d = sum[WIDTH];
                end
                MODE_NOISE: begin
                    acc_d  = noise_acc;
                    wrap_d = noise_wrap;
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
        // Output mapping applies on every edge, including hold and load.
        out_d = (mode == MODE_SQR) ? {WIDTH{acc_d[WIDTH-1]}} : acc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= RESET_VAL;
            dir_q  <= DIR_DOWN;
            out_q  <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            dir_q  <= dir_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.wrap    = wrap_q;
    assign bus.dbg_dir = dir_q;

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen: a driver pushes expected {wrap,out} per edge,
// a monitor pops and compares one sample after each rising edge.
module tb_wave_gen;
  localparam int W    = 17;
  localparam int MAXV = 65535;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  int m_acc;
  bit m_dir;

  logic [W-1:0] seq2 [9] = '{17'h04000, 17'h08000, 17'h0C000, 17'h0FFFF, 17'h0BFFF,
                             17'h07FFF, 17'h03FFF, 17'h10000, 17'h04000};
  logic [W-1:0] seq3 [3] = '{17'h17FFF, 17'h0FFFF, 17'h17FFF};
  logic [W-1:0] seq4 [4] = '{17'h00000, 17'h0FFFF, 17'h0FFFF, 17'h10000};
  logic [W-1:0] seq5 [3] = '{17'h0B400, 17'h05A00, 17'h02D00};

  wave_gen_if #(.WIDTH(16)) bus ();

  wave_gen #(
    .WIDTH(16),
    .TAPS(16'hB400),
    .RESET_VAL(16'hFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_acc = MAXV;
    m_dir = 1'b0;
  endtask

  // Reference model: plain integer arithmetic on the waveform rules.
  task automatic model_step(input logic ld, input logic e, input logic [1:0] md,
                            input logic [15:0] st, input logic [15:0] sd,
                            output logic [W-1:0] res);
    int a;
    int s;
    bit w;
    a = m_acc;
    s = int'(st);
    w = 1'b0;
    if (ld) begin
      a     = int'(sd);
      m_dir = 1'b1;
    end else if (e) begin
      case (md)
        2'd0: begin
          if (s != 0) begin
            if (m_dir) begin
              if (a + s >= MAXV) begin
                a     = MAXV;
                m_dir = 1'b0;
              end else begin
                a = a + s;
              end
            end else begin
              if (a - s <= 0) begin
                a     = 0;
                m_dir = 1'b1;
                w     = 1'b1;
              end else begin
                a = a - s;
              end
            end
          end
        end
        2'd1, 2'd2: begin
          a = a + s;
          if (a > MAXV) begin
            a = a - 65536;
            w = 1'b1;
          end
        end
        default: begin
          if (a == 0) a = 1;
          else a = (a / 2) ^ (((a % 2) == 1) ? 32'hB400 : 32'h0);
          w = (a == MAXV);
        end
      endcase
    end
    m_acc = a;
    res[16] = w;
    if (md == 2'd2) res[15:0] = (a >= 32768) ? 16'hFFFF : 16'h0000;
    else            res[15:0] = a[15:0];
  endtask

  // driver
  task automatic drive(input logic ld, input logic e, input logic [1:0] md,
                       input logic [15:0] st, input logic [15:0] sd,
                       input bit use_exp, input logic [W-1:0] exp_v, input string nm);
    logic [W-1:0] r;
    @(negedge clk);
    bus.load = ld;
    bus.en   = e;
    bus.mode = md;
    bus.step = st;
    bus.seed = sd;
    model_step(ld, e, md, st, sd, r);
    exp_q.push_back(use_exp ? exp_v : r);
    name_q.push_back(nm);
  endtask

  task automatic do_reset_mid(input string nm);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({nm, "_out"}, {16'h0, bus.out}, 32'hFFFF);
    check({nm, "_wrap"}, {31'h0, bus.wrap}, 32'h0);
    bus.en   = 1'b0;
    bus.load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // monitor / scoreboard
  logic [W-1:0] mon_e;
  string        mon_n;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      check(mon_n, {15'h0, bus.wrap, bus.out}, {15'h0, mon_e});
    end
  end

  initial begin
    int guard;
    logic [1:0]  md;
    logic [15:0] st;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.mode = 2'd0;
    bus.step = 16'h0;
    bus.seed = 16'h0;
    model_reset();
    #2;
    check("reset_out", {16'h0, bus.out}, 32'hFFFF);
    check("reset_wrap", {31'h0, bus.wrap}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // triangle step 1 from reset: full descent to the bottom wrap
    drive(0, 1, 0, 16'd1, 16'h0, 1, 17'h0FFFE, "tri1_e1");
    drive(0, 1, 0, 16'd1, 16'h0, 1, 17'h0FFFD, "tri1_e2");
    drive(0, 1, 0, 16'd1, 16'h0, 1, 17'h0FFFC, "tri1_e3");
    for (int i = 4; i <= 65534; i++)
      drive(0, 1, 0, 16'd1, 16'h0, 0, 17'h0, "tri1_mid");
    drive(0, 1, 0, 16'd1, 16'h0, 1, 17'h10000, "tri1_bottom");
    drive(0, 1, 0, 16'd1, 16'h0, 1, 17'h00001, "tri1_up1");
    drive(0, 1, 0, 16'd1, 16'h0, 1, 17'h00002, "tri1_up2");

    // triangle step 4000 from load 0
    drive(1, 0, 0, 16'h4000, 16'h0000, 1, 17'h00000, "tri2_load");
    foreach (seq2[i]) drive(0, 1, 0, 16'h4000, 16'h0, 1, seq2[i], "tri2_seq");

    // sawtooth from reset, half-range step: wrap on consecutive-but-one edges
    do_reset_mid("rst_tri");
    foreach (seq3[i]) drive(0, 1, 1, 16'h8000, 16'h0, 1, seq3[i], "saw_seq");

    // square
    drive(1, 0, 2, 16'h4000, 16'h0000, 1, 17'h00000, "sqr_load");
    foreach (seq4[i]) drive(0, 1, 2, 16'h4000, 16'h0, 1, seq4[i], "sqr_seq");

    // noise
    drive(1, 0, 3, 16'h0, 16'h0001, 1, 17'h00001, "nse_load1");
    foreach (seq5[i]) drive(0, 1, 3, 16'h0, 16'h0, 1, seq5[i], "nse_seq");
    for (int i = 0; i < 20; i++) drive(0, 1, 3, 16'h0, 16'h0, 0, 17'h0, "nse_run");
    drive(1, 0, 3, 16'h0, 16'h0000, 1, 17'h00000, "nse_load0");
    drive(0, 1, 3, 16'h0, 16'h0, 1, 17'h00001, "nse_escape");
    drive(1, 0, 3, 16'h0, 16'h97FF, 1, 17'h097FF, "nse_loadpre");
    drive(0, 1, 3, 16'h0, 16'h0, 1, 17'h1FFFF, "nse_wrap");

    // reset mid-triangle, load+en priority, en low freeze
    drive(1, 0, 0, 16'h0100, 16'h0000, 1, 17'h00000, "t6_load");
    drive(0, 1, 0, 16'h0100, 16'h0, 1, 17'h00100, "t6_up1");
    drive(0, 1, 0, 16'h0100, 16'h0, 1, 17'h00200, "t6_up2");
    do_reset_mid("rst_mid");
    drive(1, 1, 0, 16'h0100, 16'h1234, 1, 17'h01234, "t6_load_en");
    drive(0, 0, 0, 16'h0100, 16'h0, 1, 17'h01234, "t6_hold1");
    drive(0, 0, 0, 16'h0100, 16'h0, 1, 17'h01234, "t6_hold2");
    drive(0, 1, 0, 16'h0100, 16'h0, 1, 17'h01334, "t6_resume");
    drive(0, 1, 0, 16'h0000, 16'h0, 1, 17'h01334, "t6_step0");

    // randomized traffic against the model
    md = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset_mid("rst_rand");
      if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       st = 16'h0;
        1:       st = 16'($urandom_range(1, 16));
        2:       st = 16'($urandom_range(0, 65535));
        default: st = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h4000;
      endcase
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 8), md, st,
            16'($urandom_range(0, 65535)), 0, 17'h0, "rand");
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
